// File: rtl/stand_light_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | stand_light_pkg : shared types and defaults for the stand-light ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package stand_light_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_e;

  localparam int LVL_OFF         = 0;
  localparam int DEF_N_LEVELS    = 4;
  localparam int DEF_TIMEOUT_CYC = 1000;

endpackage

`default_nettype wire

// File: rtl/stand_light_ctrl_if.sv
// +----------------------------------------------------------------------+
// | stand_light_ctrl_if : button/LED bundle between the edge detectors,  |
// | the level controller and the pattern generators.  Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

interface stand_light_ctrl_if
  import stand_light_pkg::*;
#(
  parameter int N_LEVELS = DEF_N_LEVELS
);
  localparam int SEL_W = $clog2(N_LEVELS + 1);

  logic                i_btn_up;
  logic                i_btn_down;
  logic                i_btn_off;
  logic [N_LEVELS-1:0] i_x;
  logic                o_y;
  logic [SEL_W-1:0]    o_level;

  modport master (
    output i_btn_up, i_btn_down, i_btn_off, i_x,
    input  o_y, o_level
  );

  modport slave (
    input  i_btn_up, i_btn_down, i_btn_off, i_x,
    output o_y, o_level
  );

endinterface

`default_nettype wire

// File: rtl/stand_light_ctrl_timer.sv
// +----------------------------------------------------------------------+
// | stand_light_timer : idle counter, expires on its TIMEOUT_CYC-th      |
// | enabled cycle.  Rev 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module stand_light_timer
  import stand_light_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_expire = i_en && (cnt_q == C_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (i_clr || o_expire) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/stand_light_ctrl.sv
// +----------------------------------------------------------------------+
// | stand_light_ctrl : button-driven level FSM with wrap, auto-off timer |
// | and registered N-way LED select.  Rev 1.0                            |
// +----------------------------------------------------------------------+
`default_nettype none

module stand_light_ctrl
  import stand_light_pkg::*;
#(
  parameter int N_LEVELS    = DEF_N_LEVELS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset_n,
  stand_light_ctrl_if.slave  bus
);
  localparam int SEL_W = $clog2(N_LEVELS + 1);

  state_e           st_q, st_d;
  logic [SEL_W-1:0] level_q, level_d;
  logic             y_q, y_d;

  logic w_up_only, w_dn_only, w_any_btn, w_lvl_bad, w_expire;

  assign w_up_only = bus.i_btn_up & ~bus.i_btn_down;
  assign w_dn_only = bus.i_btn_down & ~bus.i_btn_up;
  assign w_any_btn = bus.i_btn_up | bus.i_btn_down | bus.i_btn_off;
  assign w_lvl_bad = (level_q > SEL_W'(N_LEVELS));

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      logic w_clr, w_en;
      assign w_clr = w_any_btn || (st_q == ST_OFF);
      assign w_en  = (st_q == ST_ON) && !w_any_btn;

      stand_light_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .o_expire (w_expire)
      );
    end else begin : g_no_timer
      assign w_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    level_d = level_q;
    if (bus.i_btn_off || w_lvl_bad) begin
      level_d = SEL_W'(LVL_OFF);
    end else if (w_up_only) begin
      level_d = (level_q == SEL_W'(N_LEVELS)) ? SEL_W'(LVL_OFF) : level_q + SEL_W'(1);
    end else if (w_dn_only) begin
      // Down saturates at level 1 and never turns the light off.
      if (level_q > SEL_W'(1)) level_d = level_q - SEL_W'(1);
    end else if (w_expire) begin
      level_d = SEL_W'(LVL_OFF);
    end
    st_d = (level_d == SEL_W'(LVL_OFF)) ? ST_OFF : ST_ON;
  end

  // Unmatched codes (off or corrupted) select nothing and drive 0.
  always_comb begin
    y_d = 1'b0;
    for (int k = 1; k <= N_LEVELS; k++) begin
      if (level_q == SEL_W'(k)) y_d = bus.i_x[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= ST_OFF;
      level_q <= SEL_W'(LVL_OFF);
      y_q     <= 1'b0;
    end else begin
      st_q    <= st_d;
      level_q <= level_d;
      y_q     <= y_d;
    end
  end

  assign bus.o_level = level_q;
  assign bus.o_y     = y_q;

endmodule

`default_nettype wire

// File: tb/tb_stand_light_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_stand_light_ctrl : randomized and directed bench with a level     |
// | reference model.  Rev 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_stand_light_ctrl;
  import stand_light_pkg::*;

  localparam int N   = DEF_N_LEVELS;
  localparam int TO  = 16;
  localparam int SW  = $clog2(N + 1);

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  int   m_level;
  int   m_idle;
  logic m_y;

  stand_light_ctrl_if #(.N_LEVELS(N)) bus  ();
  stand_light_ctrl_if #(.N_LEVELS(N)) bus0 ();

  stand_light_ctrl #(.N_LEVELS(N), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  stand_light_ctrl #(.N_LEVELS(N), .TIMEOUT_CYC(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_level = 0;
    m_idle  = 0;
    m_y     = 1'b0;
  endfunction

  // Behavioural rules: idle counts elapsed lit cycles; light goes out once TO have passed.
  function automatic void model_step(input logic up, input logic dn, input logic off,
                                     input logic [N-1:0] x);
    m_y = (m_level == 0) ? 1'b0 : x[m_level-1];
    if (off) begin
      m_level = 0;
      m_idle  = 0;
    end else if (up && !dn) begin
      m_level = (m_level + 1) % (N + 1);
      m_idle  = 0;
    end else if (dn && !up) begin
      if (m_level > 1) m_level = m_level - 1;
      m_idle = 0;
    end else if (up && dn) begin
      m_idle = 0;
    end else if (m_level == 0) begin
      m_idle = 0;
    end else begin
      m_idle = m_idle + 1;
      if (m_idle == TO) begin
        m_level = 0;
        m_idle  = 0;
      end
    end
  endfunction

  task automatic cycle(input logic up, input logic dn, input logic off);
    bus.i_btn_up   = up;
    bus.i_btn_down = dn;
    bus.i_btn_off  = off;
    @(posedge clk);
    model_step(up, dn, off, bus.i_x);
    #1;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_down = 1'b0;
    bus.i_btn_off  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if (bus.o_level !== SW'(0) || bus.o_y !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%0d y=%b required level=0 y=0", bus.o_level, bus.o_y);
    end
    bus.i_x = 4'b0100;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_level !== SW'(3) || bus.o_y !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_level3: level=%0d y=%b required level=3 y=1", bus.o_level, bus.o_y);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.o_level !== SW'(0) || bus.o_y !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: level=%0d y=%b required level=0 y=0", bus.o_level, bus.o_y);
    end
    #3 reset_n = 1'b1;
    model_reset();
    bus.i_x = 4'b1010;
    @(posedge clk); #1;
  endtask

  task automatic test_up_cycling();
    int exp_lvl [5] = '{1, 2, 3, 4, 0};
    logic exp_y [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.o_level !== SW'(exp_lvl[i]) || m_level != exp_lvl[i]) begin
        errors++;
        $display("FAIL up_level[%0d]: level=%0d required %0d", i, bus.o_level, exp_lvl[i]);
      end
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.o_y !== exp_y[i]) begin
        errors++;
        $display("FAIL up_y[%0d]: y=%b required %b", i, bus.o_y, exp_y[i]);
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_down_priority();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.o_level !== SW'(1)) begin
        errors++;
        $display("FAIL down_sat[%0d]: level=%0d required 1", i, bus.o_level);
      end
    end
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.o_level !== SW'(1)) begin
      errors++;
      $display("FAIL up_and_down: level=%0d required 1", bus.o_level);
    end
    cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.o_level !== SW'(0)) begin
      errors++;
      $display("FAIL off_beats_up: level=%0d required 0", bus.o_level);
    end
  endtask

  task automatic test_timeout();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.o_level !== SW'((i < TO) ? 1 : 0)) begin
        errors++;
        $display("FAIL timeout_plain[%0d]: level=%0d required %0d", i, bus.o_level, (i < TO) ? 1 : 0);
      end
    end
    cycle(1'b1, 1'b0, 1'b0);
    repeat (9) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.o_level !== SW'((i < TO) ? 1 : 0)) begin
        errors++;
        $display("FAIL timeout_restart[%0d]: level=%0d required %0d", i, bus.o_level, (i < TO) ? 1 : 0);
      end
    end
  endtask

  task automatic test_live_source();
    logic prev;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      prev = bus.i_x[1];
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.o_y !== prev || bus.o_y !== m_y) begin
        errors++;
        $display("FAIL live_src[%0d]: y=%b required %b", i, bus.o_y, prev);
      end
      bus.i_x[1] = ~bus.i_x[1];
    end
    cycle(1'b0, 1'b0, 1'b1);
    bus.i_x = 4'b1010;
  endtask

  task automatic test_random();
    int r;
    logic up, dn, off;
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 39));
      up  = (r == 0) || (r == 3);
      dn  = (r == 1) || (r == 3);
      off = (r == 2) && ($urandom_range(0, 3) == 0);
      bus.i_x = 4'($urandom);
      cycle(up, dn, off);
      checks++;
      if (bus.o_level !== SW'(m_level) || bus.o_y !== m_y) begin
        errors++;
        $display("FAIL random[%0d]: level=%0d y=%b required level=%0d y=%b",
                 i, bus.o_level, bus.o_y, m_level, m_y);
      end
    end
    bus.i_x = 4'b1010;
  endtask

  task automatic test_no_timeout();
    bus0.i_btn_up = 1'b1;
    @(posedge clk); #1;
    bus0.i_btn_up = 1'b0;
    checks++;
    if (bus0.o_level !== SW'(1)) begin
      errors++;
      $display("FAIL notimer_on: level=%0d required 1", bus0.o_level);
    end
    repeat (5000) @(posedge clk);
    #1;
    checks++;
    if (bus0.o_level !== SW'(1) || bus0.o_y !== 1'b1) begin
      errors++;
      $display("FAIL notimer_5000: level=%0d y=%b required level=1 y=1", bus0.o_level, bus0.o_y);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b1;
    bus.i_btn_up = 1'b0;  bus.i_btn_down = 1'b0;  bus.i_btn_off = 1'b0;
    bus.i_x = 4'b1010;
    bus0.i_btn_up = 1'b0; bus0.i_btn_down = 1'b0; bus0.i_btn_off = 1'b0;
    bus0.i_x = 4'b0001;
    model_reset();
    #2;
    test_reset();
    test_up_cycling();
    test_down_priority();
    test_timeout();
    test_live_source();
    test_random();
    test_no_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
